// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: 4-bit operation codes, FSM state
// encoding and a small decode helper. Code 1001 (ALU_SLTU) is only honoured
// when the ALU_SLTU_EN macro is defined; otherwise it executes as ADD.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } alu_state_t;

    // True for the three codes handled by the bit-serial shifter.
    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Single-cycle combinational part of the ALU: ADD/SUB/AND/OR/XOR/SLT, plus
// SLTU when ALU_SLTU_EN is defined. Shift codes and undefined codes fall
// through to ADD; the top selects the shifter path for shifts.
module alu_logic_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] res
);

    logic w_lt_signed;
`ifdef ALU_SLTU_EN
    logic w_lt_unsigned;
    assign w_lt_unsigned = (op_a < op_b);
`endif

    assign w_lt_signed = ($signed(op_a) < $signed(op_b));

    // Decode the operation; anything not listed behaves as ADD.
    always_comb begin
        res = op_a + op_b;
        case (alu_ctrl)
            ALU_SUB: res = op_a - op_b;
            ALU_AND: res = op_a & op_b;
            ALU_OR:  res = op_a | op_b;
            ALU_XOR: res = op_a ^ op_b;
            ALU_SLT: res = {{(XLEN-1){1'b0}}, w_lt_signed};
`ifdef ALU_SLTU_EN
            ALU_SLTU: res = {{(XLEN-1){1'b0}}, w_lt_unsigned};
`endif
            default: res = op_a + op_b;
        endcase
    end

endmodule

// File: rtl/alu_iterative.sv
// Area-reduced execute-stage ALU. Non-shift operations finish in one registered
// cycle; SLL/SRL/SRA shift one bit per cycle. Valid/ready on both sides, with
// no overlap between consecutive operations (IDLE -> SHIFT -> DONE).
// Optional feature: define ALU_SLTU_EN to enable code 1001 as SLTU.
module alu_iterative
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int unsigned ShW = $clog2(XLEN);
    localparam logic [ShW-1:0] CntOne = ShW'(1);

    alu_state_t      r_state;
    alu_state_t      w_state_next;
    logic [XLEN-1:0] r_acc;
    logic [ShW-1:0]  r_cnt;
    logic [3:0]      r_ctrl;
    logic [XLEN-1:0] r_result;

    logic [ShW-1:0]  w_shamt;
    logic            w_accept;
    logic            w_shift_start;
    logic [XLEN-1:0] w_logic_res;
    logic [XLEN-1:0] w_imm_res;
    logic [XLEN-1:0] w_acc_shift;

    assign w_shamt       = op_b[ShW-1:0];
    assign w_accept      = in_valid && (r_state == StIdle);
    assign w_shift_start = is_shift(alu_ctrl) && (w_shamt != '0);

    alu_logic_unit #(
        .XLEN (XLEN)
    ) u_logic (
        .alu_ctrl (alu_ctrl),
        .op_a     (op_a),
        .op_b     (op_b),
        .res      (w_logic_res)
    );

    // A shift by zero is a pass-through of op_a and completes like a logic op.
    assign w_imm_res = is_shift(alu_ctrl) ? op_a : w_logic_res;

    // One-bit step of the serial shifter, selected by the latched code.
    always_comb begin
        w_acc_shift = {r_acc[XLEN-2:0], 1'b0};
        case (r_ctrl)
            ALU_SRL: w_acc_shift = {1'b0, r_acc[XLEN-1:1]};
            ALU_SRA: w_acc_shift = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
            default: w_acc_shift = {r_acc[XLEN-2:0], 1'b0};
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = w_shift_start ? StShift : StDone;
                end
            end
            StShift: begin
                if (r_cnt == CntOne) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
        zero = out_valid && (r_result == '0);
    end

    // Datapath: operand latch, shift accumulator/counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_ctrl   <= ALU_ADD;
            r_result <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_ctrl <= alu_ctrl;
                        if (w_shift_start) begin
                            r_acc <= op_a;
                            r_cnt <= w_shamt;
                        end else begin
                            r_result <= w_imm_res;
                        end
                    end
                end
                StShift: begin
                    r_acc <= w_acc_shift;
                    r_cnt <= r_cnt - CntOne;
                    if (r_cnt == CntOne) begin
                        r_result <= w_acc_shift;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed self-checking bench for alu_iterative with a result scoreboard.
// Honours ALU_SLTU_EN so the expected value of code 1001 tracks the build.
module tb_alu_iterative;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb[$];

    alu_iterative #(
        .XLEN (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return $signed(a) >>> sh;
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_SLTU_EN
            4'd9: return (a < b) ? 32'd1 : 32'd0;
`endif
            default: return a + b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [3:0] c, input logic [31:0] b);
        if ((c == 4'd5 || c == 4'd6 || c == 4'd7) && b[4:0] != 5'd0) begin
            return int'(b[4:0]) + 1;
        end
        return 1;
    endfunction

    // Drive one op, scramble inputs after accept, wait for out_valid, check, release.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b);
        int lat;
        logic ir_low;
        logic [31:0] exp;
        sb.push_back(model(c, a, b));
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        tick();
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat      = 1;
        ir_low   = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) ir_low = 1'b0;
            tick();
            lat++;
        end
        if (in_ready) ir_low = 1'b0;
        exp = sb.pop_front();
        check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, " latency"}, lat, exp_latency(c, b));
        check({tag, " in_ready_low"}, {31'd0, ir_low}, 32'd1);
        check({tag, " result"}, result, exp);
        check({tag, " zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] exp;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctrl  = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        tick();
        tick();
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst result", result, 32'd0);
        check("rst zero", {31'd0, zero}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

        run_op("add_ovf",  4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        run_op("sub_zero", 4'd1, 32'd5, 32'd5);
        run_op("sub_neg",  4'd1, 32'd0, 32'd1);
        run_op("sra31",    4'd7, 32'h8000_0000, 32'd31);
        run_op("sll_sh0",  4'd5, 32'd1, 32'h0000_0020);
        run_op("slt_t",    4'd8, 32'hFFFF_FFFF, 32'd1);
        run_op("slt_f",    4'd8, 32'd1, 32'hFFFF_FFFF);
        run_op("and",      4'd2, 32'hF0F0_1234, 32'hFF00_FF00);
        run_op("or",       4'd3, 32'hF0F0_1234, 32'h0F00_0001);
        run_op("xor",      4'd4, 32'hAAAA_5555, 32'hFFFF_0000);
        run_op("srl7",     4'd6, 32'h8123_4567, 32'hFFFF_FFE7);
        run_op("sll1",     4'd5, 32'h8000_0003, 32'd1);
        run_op("sra4pos",  4'd7, 32'h7000_0000, 32'd4);
        run_op("undef",    4'd15, 32'd10, 32'd20);
        run_op("code1001", 4'd9, 32'd1, 32'hFFFF_FFFF);

        // Backpressure: result must hold while out_ready stays low.
        exp = model(4'd0, 32'd3, 32'd4);
        sb.push_back(exp);
        in_valid = 1'b1;
        alu_ctrl = 4'd0;
        op_a     = 32'd3;
        op_b     = 32'd4;
        tick();
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        exp = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op_a     = $urandom;
            check("bp result", result, exp);
            check("bp out_valid", {31'd0, out_valid}, 32'd1);
            check("bp in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release out_valid", {31'd0, out_valid}, 32'd0);
        check("bp release in_ready", {31'd0, in_ready}, 32'd1);
        run_op("after_bp", 4'd1, 32'd100, 32'd58);

        // Reset in the middle of a 20-bit SRL aborts it.
        in_valid = 1'b1;
        alu_ctrl = 4'd6;
        op_a     = 32'hFFFF_0000;
        op_b     = 32'd20;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("mid busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort zero", {31'd0, zero}, 32'd0);
        run_op("post_abort", 4'd0, 32'h1234_0000, 32'h0000_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
